// File: rtl/fu_muldiv_sched.sv
// Serialises lane A/B multiply-divide requests onto one shared iterative MDU,
// stalling the pipeline until every accepted request has produced its result.
module fu_muldiv_sched #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_req_a,
  input  logic              EX_req_b,
  input  logic [OP_W-1:0]   EX_op_a,
  input  logic [OP_W-1:0]   EX_op_b,
  input  logic [DATA_W-1:0] EX_src_a1,
  input  logic [DATA_W-1:0] EX_src_a2,
  input  logic [DATA_W-1:0] EX_src_b1,
  input  logic [DATA_W-1:0] EX_src_b2,
  input  logic              EX_br_a,
  input  logic              flush,
  output logic              md_start,
  output logic [OP_W-1:0]   md_op,
  output logic [DATA_W-1:0] md_src1,
  output logic [DATA_W-1:0] md_src2,
  input  logic              md_done,
  input  logic [DATA_W-1:0] md_result,
  output logic              stall,
  output logic              EX_md_valid_a,
  output logic              EX_md_valid_b,
  output logic [DATA_W-1:0] EX_md_result_a,
  output logic [DATA_W-1:0] EX_md_result_b
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_A = 3'd1,
    RUN_B = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state, state_nx;

  logic              need_a;
  logic              need_b;
  logic              accept;
  logic              running;
  logic              done_ok;
  logic              enter_run;
  logic              pend_b;
  logic              served_a;
  logic              served_b;
  logic [OP_W-1:0]   op_b_q;
  logic [DATA_W-1:0] src_b1_q;
  logic [DATA_W-1:0] src_b2_q;

  assign need_a  = EX_req_a;
  assign need_b  = EX_req_b & ~EX_br_a;
  assign accept  = (state == IDLE) & ~flush & (need_a | need_b);
  assign running = (state == RUN_A) | (state == RUN_B);
  // A done in the start cycle cannot belong to the op being started.
  assign done_ok = running & md_done & ~md_start;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = need_a ? RUN_A : RUN_B;
      end
      RUN_A: begin
        if (flush)        state_nx = done_ok ? IDLE : DRAIN;
        else if (done_ok) state_nx = pend_b ? RUN_B : DONE;
      end
      RUN_B: begin
        if (flush)        state_nx = done_ok ? IDLE : DRAIN;
        else if (done_ok) state_nx = DONE;
      end
      DONE:  state_nx = IDLE;
      DRAIN: begin
        if (md_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign enter_run = ((state_nx == RUN_A) | (state_nx == RUN_B)) & (state_nx != state);

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:                stall = accept;
      RUN_A, RUN_B, DRAIN: stall = 1'b1;
      default:             stall = 1'b0;
    endcase
  end

  assign EX_md_valid_a = (state == DONE) & served_a;
  assign EX_md_valid_b = (state == DONE) & served_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      md_start       <= 1'b0;
      md_op          <= '0;
      md_src1        <= '0;
      md_src2        <= '0;
      pend_b         <= 1'b0;
      served_a       <= 1'b0;
      served_b       <= 1'b0;
      op_b_q         <= '0;
      src_b1_q       <= '0;
      src_b2_q       <= '0;
      EX_md_result_a <= '0;
      EX_md_result_b <= '0;
    end else begin
      state    <= state_nx;
      md_start <= enter_run;

      if (accept) begin
        pend_b   <= need_b;
        served_a <= need_a;
        served_b <= need_b;
        op_b_q   <= EX_op_b;
        src_b1_q <= EX_src_b1;
        src_b2_q <= EX_src_b2;
        if (need_a) begin
          md_op   <= EX_op_a;
          md_src1 <= EX_src_a1;
          md_src2 <= EX_src_a2;
        end else begin
          md_op   <= EX_op_b;
          md_src1 <= EX_src_b1;
          md_src2 <= EX_src_b2;
        end
      end else if ((state == RUN_A) && (state_nx == RUN_B)) begin
        pend_b  <= 1'b0;
        md_op   <= op_b_q;
        md_src1 <= src_b1_q;
        md_src2 <= src_b2_q;
      end

      // A flushed op's result is dropped even when it lands this cycle.
      if (done_ok && !flush) begin
        if (state == RUN_A) EX_md_result_a <= md_result;
        else                EX_md_result_b <= md_result;
      end
    end
  end

endmodule

// File: tb/tb_fu_muldiv_sched.sv
// Directed bench for fu_muldiv_sched with a fixed-latency behavioural MDU
// (done arrives L cycles after the start cycle) and injectable spurious dones.
module tb_fu_muldiv_sched;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int LAT    = 3;
  localparam logic [OP_W-1:0] OP_MUL = 4'd0;
  localparam logic [OP_W-1:0] OP_DIV = 4'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic              EX_req_a, EX_req_b, EX_br_a, flush;
  logic [OP_W-1:0]   EX_op_a, EX_op_b;
  logic [DATA_W-1:0] EX_src_a1, EX_src_a2, EX_src_b1, EX_src_b2;
  logic              md_start, md_done, stall;
  logic [OP_W-1:0]   md_op;
  logic [DATA_W-1:0] md_src1, md_src2, md_result;
  logic              EX_md_valid_a, EX_md_valid_b;
  logic [DATA_W-1:0] EX_md_result_a, EX_md_result_b;

  logic              model_done = 1'b0;
  logic [DATA_W-1:0] model_res = '0;
  logic [DATA_W-1:0] res_calc = '0;
  logic              inj_done = 1'b0;
  logic [DATA_W-1:0] inj_val = '0;
  int                cnt = 0;

  int total = 0;
  int bad   = 0;
  int starts = 0, stall_cnt = 0, va_cnt = 0, vb_cnt = 0;
  logic counting = 1'b0;
  logic found;

  assign md_done   = model_done | inj_done;
  assign md_result = inj_done ? inj_val : model_res;

  always #5 clk = ~clk;

  fu_muldiv_sched #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .EX_req_a(EX_req_a), .EX_req_b(EX_req_b),
    .EX_op_a(EX_op_a), .EX_op_b(EX_op_b),
    .EX_src_a1(EX_src_a1), .EX_src_a2(EX_src_a2),
    .EX_src_b1(EX_src_b1), .EX_src_b2(EX_src_b2),
    .EX_br_a(EX_br_a), .flush(flush),
    .md_start(md_start), .md_op(md_op), .md_src1(md_src1), .md_src2(md_src2),
    .md_done(md_done), .md_result(md_result),
    .stall(stall),
    .EX_md_valid_a(EX_md_valid_a), .EX_md_valid_b(EX_md_valid_b),
    .EX_md_result_a(EX_md_result_a), .EX_md_result_b(EX_md_result_b)
  );

  // Behavioural MDU: start seen in cycle s, done driven through cycle s+LAT.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          model_done = 1'b1;
          model_res  = res_calc;
        end
      end
      if (md_start) begin
        cnt = LAT;
        res_calc = (md_op == OP_DIV) ? (md_src1 / md_src2) : (md_src1 * md_src2);
      end
    end
  end

  always @(negedge clk) begin
    if (md_start) begin
      starts = starts + 1;
      counting = 1'b1;
    end
    if (counting && stall) stall_cnt = stall_cnt + 1;
    if (EX_md_valid_a) va_cnt = va_cnt + 1;
    if (EX_md_valid_b) vb_cnt = vb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    starts = 0; stall_cnt = 0; va_cnt = 0; vb_cnt = 0; counting = 1'b0;
  endtask

  task automatic idle_inputs();
    EX_req_a = 0; EX_req_b = 0; EX_br_a = 0; flush = 0;
  endtask

  task automatic drive(input logic ra, input logic rb, input logic br,
                       input logic [OP_W-1:0] oa, input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] a2,
                       input logic [OP_W-1:0] ob, input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2);
    EX_req_a = ra; EX_req_b = rb; EX_br_a = br;
    EX_op_a = oa; EX_src_a1 = a1; EX_src_a2 = a2;
    EX_op_b = ob; EX_src_b1 = b1; EX_src_b2 = b2;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      @(posedge clk);
      #2;
      if (EX_md_valid_a || EX_md_valid_b) found = 1'b1;
      n = n + 1;
    end
    chk("wait_done_timeout", {63'd0, found}, 64'd1);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    drive(0, 0, 0, '0, '0, '0, '0, '0, '0);
    step(); step();
    rst = 0;
    settle();
    chk("rst_md_start", md_start, 0);
    chk("rst_md_src1", md_src1, 0);
    chk("rst_valid_a", EX_md_valid_a, 0);
    chk("rst_result_a", EX_md_result_a, 0);
    chk("rst_stall", stall, 0);

    // Lane A only: 7*6
    clr();
    step();
    drive(1, 0, 0, OP_MUL, 7, 6, OP_MUL, 0, 0);
    settle();
    chk("t1_accept_stall", stall, 1);
    step();
    idle_inputs();
    settle();
    chk("t1_md_start", md_start, 1);
    chk("t1_md_op", md_op, OP_MUL);
    chk("t1_md_src1", md_src1, 7);
    chk("t1_md_src2", md_src2, 6);
    wait_valid(20);
    chk("t1_valid_a", EX_md_valid_a, 1);
    chk("t1_valid_b", EX_md_valid_b, 0);
    chk("t1_result_a", EX_md_result_a, 42);
    chk("t1_done_stall", stall, 0);
    chk("t1_starts", starts, 1);
    chk("t1_stall_cycles", stall_cnt, 4);
    step(); settle();
    chk("t1_valid_after", EX_md_valid_a, 0);
    chk("t1_result_hold", EX_md_result_a, 42);

    // Both lanes: A 100/7, B 9*9
    clr();
    drive(1, 1, 0, OP_DIV, 100, 7, OP_MUL, 9, 9);
    step();
    idle_inputs();
    wait_valid(30);
    chk("t2_valid_a", EX_md_valid_a, 1);
    chk("t2_valid_b", EX_md_valid_b, 1);
    chk("t2_result_a", EX_md_result_a, 14);
    chk("t2_result_b", EX_md_result_b, 81);
    chk("t2_starts", starts, 2);
    chk("t2_stall_cycles", stall_cnt, 8);

    // Branch on A squashes B at acceptance
    step();
    clr();
    drive(1, 1, 1, OP_MUL, 5, 5, OP_MUL, 3, 3);
    step();
    idle_inputs();
    wait_valid(30);
    chk("t3_valid_a", EX_md_valid_a, 1);
    chk("t3_valid_b", EX_md_valid_b, 0);
    chk("t3_result_a", EX_md_result_a, 25);
    chk("t3_result_b_hold", EX_md_result_b, 81);
    chk("t3_starts", starts, 1);
    chk("t3_stall_cycles", stall_cnt, 4);

    // Flush in IDLE blocks acceptance
    step();
    drive(1, 0, 0, OP_MUL, 1, 1, OP_MUL, 0, 0);
    flush = 1;
    settle();
    chk("t4_idle_flush_stall", stall, 0);
    step();
    idle_inputs();
    settle();
    chk("t4_idle_flush_start", md_start, 0);

    // Flush during RUN_A (second cycle) with B pending
    clr();
    step();
    drive(1, 1, 0, OP_MUL, 2, 3, OP_MUL, 4, 4);
    step();                       // RUN_A start cycle
    idle_inputs();
    step();                       // RUN_A cycle 2
    flush = 1;
    settle();
    chk("t4_flush_stall", stall, 1);
    step();                       // DRAIN
    flush = 0;
    settle();
    chk("t4_drain_stall", stall, 1);
    chk("t4_drain_no_start", md_start, 0);
    step();                       // DRAIN, MDU done arrives
    settle();
    chk("t4_done_cycle_stall", stall, 1);
    step();
    settle();
    chk("t4_after_done_stall", stall, 0);
    step(); step(); settle();
    chk("t4_starts", starts, 1);
    chk("t4_valid_a_cnt", va_cnt, 0);
    chk("t4_valid_b_cnt", vb_cnt, 0);
    chk("t4_result_a_hold", EX_md_result_a, 25);
    chk("t4_result_b_hold", EX_md_result_b, 81);

    // Spurious done in IDLE, then coincident with md_start
    clr();
    inj_val = 32'hDEAD_BEEF;
    inj_done = 1;
    step();
    inj_done = 0;
    settle();
    chk("t5_idle_done_valid", EX_md_valid_a, 0);
    chk("t5_idle_done_stall", stall, 0);
    chk("t5_idle_done_res", EX_md_result_a, 25);
    drive(1, 0, 0, OP_MUL, 4, 5, OP_MUL, 0, 0);
    step();
    idle_inputs();
    inj_done = 1;
    settle();
    chk("t5_start_cycle", md_start, 1);
    step();
    inj_done = 0;
    settle();
    chk("t5_no_early_valid", EX_md_valid_a, 0);
    chk("t5_res_unchanged", EX_md_result_a, 25);
    wait_valid(20);
    chk("t5_valid_a", EX_md_valid_a, 1);
    chk("t5_result_a", EX_md_result_a, 20);
    chk("t5_stall_cycles", stall_cnt, 4);

    // Reset in the middle of RUN_B
    step();
    clr();
    drive(1, 1, 0, OP_MUL, 2, 2, OP_MUL, 6, 6);
    step();
    idle_inputs();
    begin
      int n;
      n = 0;
      while (starts < 2 && n < 30) begin
        @(posedge clk);
        #2;
        n = n + 1;
      end
    end
    chk("t6_reached_run_b", starts, 2);
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_start", md_start, 0);
    chk("t6_rst_md_op", md_op, 0);
    chk("t6_rst_md_src2", md_src2, 0);
    chk("t6_rst_valid_b", EX_md_valid_b, 0);
    chk("t6_rst_result_a", EX_md_result_a, 0);
    chk("t6_rst_result_b", EX_md_result_b, 0);
    clr();
    step();
    drive(1, 0, 0, OP_MUL, 12, 3, OP_MUL, 0, 0);
    step();
    idle_inputs();
    wait_valid(20);
    chk("t6_valid_a", EX_md_valid_a, 1);
    chk("t6_result_a", EX_md_result_a, 36);
    chk("t6_starts", starts, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
